// File: rtl/memory_data_sized.sv
// Byte-addressed little-endian data RAM with 1/2/4/8-byte loads and stores,
// valid/ready request and response handshakes, a fixed access latency and fault reporting.
module memory_data_sized #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WORDS  = DEPTH / 8;
    localparam int CNT_W  = 4;
    localparam int WIDX_W = ADDR_W - 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                fault_q, fault_d;

    // Any legal access is naturally aligned, so all of its bytes live in one 64-bit word.
    logic [XLEN-1:0]     mem_q [WORDS];

    logic                access;
    logic [3:0]          nbytes;
    logic [2:0]          align_mask;
    logic [7:0]          size_be;
    logic [7:0]          lane_be;
    logic [ADDR_W:0]     end_addr;
    logic                misaligned;
    logic                out_of_range;
    logic                fault;
    logic [WIDX_W-1:0]   word_idx;
    logic [XLEN-1:0]     word_rd;
    logic [XLEN-1:0]     raw;
    logic [XLEN-1:0]     load_ext;
    logic [XLEN-1:0]     wr_bits;
    logic [XLEN-1:0]     wr_mask;
    logic [XLEN-1:0]     wr_word;

    assign access = (state_q == BUSY) && (cnt_q == '0);

    always_comb begin
        align_mask = 3'b000;
        size_be    = 8'h01;
        case (size_q)
            2'd0: begin align_mask = 3'b000; size_be = 8'h01; end
            2'd1: begin align_mask = 3'b001; size_be = 8'h03; end
            2'd2: begin align_mask = 3'b011; size_be = 8'h0F; end
            default: begin align_mask = 3'b111; size_be = 8'hFF; end
        endcase
    end

    // One extra address bit keeps addr+n from wrapping past the top of the array.
    assign nbytes       = 4'd1 << size_q;
    assign end_addr     = {1'b0, addr_q} + (ADDR_W+1)'(nbytes);
    assign misaligned   = |(addr_q[2:0] & align_mask);
    assign out_of_range = end_addr > (ADDR_W+1)'(DEPTH);
    assign fault        = misaligned || out_of_range;

    assign word_idx = addr_q[ADDR_W-1:3];
    assign word_rd  = mem_q[word_idx];
    assign raw      = word_rd >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_ext = raw;
        case (size_q)
            2'd0: load_ext = {{(XLEN-8){~uns_q & raw[7]}}, raw[7:0]};
            2'd1: load_ext = {{(XLEN-16){~uns_q & raw[15]}}, raw[15:0]};
            2'd2: load_ext = {{(XLEN-32){~uns_q & raw[31]}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

    assign lane_be = size_be << addr_q[2:0];
    assign wr_bits = wdata_q << {addr_q[2:0], 3'b000};

    always_comb begin
        wr_mask = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            wr_mask[8*i +: 8] = {8{lane_be[i]}};
        end
    end

    assign wr_word = (word_rd & ~wr_mask) | (wr_bits & wr_mask);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rdata_d = (fault || we_q) ? '0 : load_ext;
                    fault_d = fault;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // The array has no reset; a store is blocked whenever reset forces state_q to IDLE.
    always_ff @(posedge clk) begin
        if (access && we_q && !fault) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule
